pattern_source: RTL and testbench

PATTERN_SOURCE -- requirements
Module: pattern_source

---
 rtl/pattern_source_pkg.sv | 24 ++
 rtl/lfsr8.sv | 11 +
 rtl/pattern_source.sv | 139 +++++++++++++
 tb/tb_pattern_source.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pattern_source_pkg.sv
// Shared types and constants for the pattern_source burst generator.
package pattern_source_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'b00,
    MODE_LFSR  = 2'b01,
    MODE_CONST = 2'b10,
    MODE_WALK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in left-shift form: bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] rotl8(input logic [7:0] w);
    return {w[6:0], w[7]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Combinational next-state of the 8-bit Fibonacci LFSR (maximal length, period 255).
module lfsr8
  import pattern_source_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {cur[6:0], ^(cur & LFSR_TAPS)};

endmodule

// File: rtl/pattern_source.sv
// Burst pattern generator: emits `length` words of a selected pattern, stallable,
// with every output registered so it can drive a chain input directly.
module pattern_source
  import pattern_source_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter logic [7:0] LFSR_SEED = 8'hE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic [LEN_W-1:0] length,
  input  logic             stall,
  output logic [7:0]       out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       gen_q, gen_d;     // next word to emit
  logic [7:0]       out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] count_q, count_d;

  mode_e      in_mode, cur_mode;
  logic [7:0] first_w, emit_w, next_w, lfsr_nxt;
  logic       emit;

  assign in_mode = mode_e'(mode);

  lfsr8 u_lfsr (
    .cur (emit_w),
    .nxt (lfsr_nxt)
  );

  always_comb begin
    unique case (in_mode)
      MODE_LFSR: first_w = (seed == 8'h00) ? LFSR_SEED : seed;
      MODE_WALK: first_w = 8'h01;
      default:   first_w = seed;
    endcase
  end

  // In IDLE the start cycle itself can emit, so it works off the live inputs.
  assign cur_mode = (state_q == ST_IDLE) ? in_mode : mode_q;
  assign emit_w   = (state_q == ST_IDLE) ? first_w : gen_q;

  always_comb begin
    unique case (cur_mode)
      MODE_COUNT: next_w = emit_w + 8'd1;
      MODE_LFSR:  next_w = lfsr_nxt;
      MODE_CONST: next_w = emit_w;
      default:    next_w = rotl8(emit_w);
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    gen_d   = gen_q;
    out_d   = out_q;
    count_d = count_q;
    valid_d = 1'b0;
    emit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = in_mode;
          len_d   = length;
          count_d = '0;
          gen_d   = first_w;
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            emit    = !stall;
          end
        end
      end
      ST_RUN: begin
        // Final word is already on out; leave on the cycle after it.
        if (count_q == len_q) state_d = ST_DONE;
        else                  emit    = !stall;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      out_d   = emit_w;
      valid_d = 1'b1;
      gen_d   = next_w;
      count_d = ((state_q == ST_IDLE) ? '0 : count_q) + LEN_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      len_q   <= '0;
      gen_q   <= 8'h00;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      gen_q   <= gen_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_pattern_source.sv
// Randomized bench for pattern_source against a word-index reference model.
module tb_pattern_source;

  localparam int         LEN_W = 16;
  localparam logic [7:0] LSEED = 8'hE1;

  logic             clk = 1'b0;
  logic             rst, start, stall;
  logic [1:0]       mode;
  logic [7:0]       seed;
  logic [LEN_W-1:0] length;
  logic [7:0]       d_out;
  logic             d_valid, d_busy, d_done;
  logic [LEN_W-1:0] d_count;

  always #5 clk = ~clk;

  pattern_source #(.LEN_W(LEN_W), .LFSR_SEED(LSEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .length(length), .stall(stall), .out(d_out), .valid(d_valid),
    .busy(d_busy), .done(d_done), .count(d_count)
  );

  // Word k of a burst, straight from the pattern definitions.
  function automatic logic [7:0] word_at(input logic [1:0] md, input logic [7:0] sd, input int k);
    logic [7:0] w;
    case (md)
      2'b00: w = sd + 8'(k);
      2'b01: begin
        w = (sd == 8'h00) ? LSEED : sd;
        for (int j = 0; j < k; j++) w = {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
      end
      2'b10: w = sd;
      default: w = 8'h01 << (k % 8);
    endcase
    return w;
  endfunction

  // Reference: phase 0 idle, 1 emitting, 2 done pulse.
  int               m_phase = 0, m_k = 0;
  logic [1:0]       l_mode;
  logic [7:0]       l_seed;
  logic [LEN_W-1:0] l_len;
  logic [7:0]       e_out;
  logic             e_valid, e_busy, e_done, armed = 1'b0;
  logic [LEN_W-1:0] e_count;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; e_out = 8'h00; e_valid = 0; e_busy = 0; e_done = 0; e_count = '0; armed = 1'b1;
    end else begin
      e_valid = 0;
      case (m_phase)
        0: begin
          e_done = 0; e_busy = 0;
          if (start) begin
            l_mode = mode; l_seed = seed; l_len = length; m_k = 0; e_count = '0; e_busy = 1;
            if (length == '0) begin m_phase = 2; e_done = 1; end
            else begin
              m_phase = 1;
              if (!stall) begin e_out = word_at(l_mode, l_seed, 0); e_valid = 1; m_k = 1; e_count = 1; end
            end
          end
        end
        1: begin
          if (m_k == int'(l_len)) begin m_phase = 2; e_done = 1; end
          else if (!stall) begin
            e_out = word_at(l_mode, l_seed, m_k); e_valid = 1; m_k++; e_count = LEN_W'(m_k);
          end
        end
        default: begin m_phase = 0; e_done = 0; e_busy = 0; end
      endcase
    end
  end

  int n_vec = 0, n_err = 0;
  bit seen [256];
  bit track = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      chk("out",   32'(d_out),   32'(e_out));
      chk("valid", 32'(d_valid), 32'(e_valid));
      chk("busy",  32'(d_busy),  32'(e_busy));
      chk("done",  32'(d_done),  32'(e_done));
      chk("count", 32'(d_count), 32'(e_count));
      if (track && d_valid === 1'b1) seen[d_out] = 1;
    end
  endtask

  task automatic run_burst(input logic [1:0] md, input logic [7:0] sd, input logic [15:0] ln,
                           input logic [31:0] smask, input int spct, input int rst_at);
    bit fin = 0;
    tick();
    start = 1; mode = md; seed = sd; length = ln; stall = smask[0]; rst = 0;
    for (int i = 1; i < 700 && !fin; i++) begin
      tick();
      if (m_phase == 0) begin
        fin = 1; start = 0; stall = 0; rst = 0;
      end else begin
        // Noise on start/mode/seed/length must be ignored mid-burst.
        start  = ($urandom_range(0, 7) == 0);
        mode   = 2'($urandom);
        seed   = 8'($urandom);
        length = LEN_W'($urandom);
        stall  = (i < 32 && smask[i]) || ($urandom_range(1, 100) <= spct);
        rst    = (i == rst_at);
      end
    end
    chk("burst_end", 32'(fin), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    int nd;
    rst = 1; start = 0; stall = 0; mode = 0; seed = 0; length = 0;
    repeat (2) tick();
    rst = 0;
    tick();

    run_burst(2'b00, 8'hFE, 4, 0, 0, -1);
    foreach (seen[i]) seen[i] = 0;
    track = 1;
    run_burst(2'b01, 8'h00, 255, 0, 0, -1);
    track = 0;
    nd = 0;
    foreach (seen[i]) nd += int'(seen[i]);
    chk("lfsr_distinct", 32'(nd), 32'd255);
    chk("lfsr_nonzero", 32'(seen[0]), 32'd0);
    run_burst(2'b11, 8'h77, 10, 32'b1100, 0, -1);
    run_burst(2'b10, 8'h33, 0, 0, 0, -1);
    run_burst(2'b10, 8'h5A, 8, 0, 0, 3);
    run_burst(2'b10, 8'h5A, 8, 0, 0, -1);
    run_burst(2'b00, 8'h10, 1, 32'b1, 0, -1);
    for (int b = 0; b < 30; b++)
      run_burst(2'($urandom), 8'($urandom), 16'($urandom_range(0, 40)), $urandom,
                $urandom_range(0, 50), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
